// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the fetch and load/store ports.
// Define ARB_FAIRNESS_EN to force a fetch grant after STREAK_MAX consecutive data grants.
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LATENCY    = 2,
    parameter int STREAK_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic          mem_ack_o,
    output logic [DW-1:0] mem_rdata_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          stall_if_o,
    output logic          stall_mem_o,
    output logic          busy_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    state_t          state;
    state_t          next_state;
    grant_t          grant;
    logic [CW-1:0]   cnt;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   mem_rdata_q;
    logic            force_i;
    logic            pick_d;
    logic            pick_i;
    logic            last_cycle;

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(STREAK_MAX + 1);
    logic [SW-1:0] streak;

    assign force_i = if_req_i && (streak == SW'(STREAK_MAX));

    // Streak only measures how long a waiting fetch has been passed over.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (!if_req_i || pick_i) begin
                streak <= '0;
            end else if (pick_d) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign pick_d     = mem_req_i && !force_i;
    assign pick_i     = if_req_i && !pick_d;
    assign last_cycle = (cnt == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if_ack_o    = 1'b0;
        mem_ack_o   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_d || pick_i) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                ram_en_o    = 1'b1;
                ram_addr_o  = lat_addr;
                ram_wdata_o = lat_wdata;
                ram_we_o    = last_cycle && (grant == GNT_D) && lat_we;
                if (last_cycle) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if_ack_o   = (grant == GNT_I);
                mem_ack_o  = (grant == GNT_D);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are latched at grant so a requester dropping mid-access cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            grant       <= GNT_NONE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d || pick_i) begin
                        grant     <= pick_d ? GNT_D : GNT_I;
                        cnt       <= CW'(LATENCY - 1);
                        lat_we    <= pick_d && mem_we_i;
                        lat_addr  <= pick_d ? mem_addr_i : if_addr_i;
                        lat_wdata <= pick_d ? mem_wdata_i : '0;
                    end
                end
                ACCESS: begin
                    if (!last_cycle) begin
                        cnt <= cnt - 1'b1;
                    end else if (grant == GNT_I) begin
                        if_rdata_q <= ram_rdata_i;
                    end else if ((grant == GNT_D) && !lat_we) begin
                        mem_rdata_q <= ram_rdata_i;
                    end
                end
                DONE: begin
                    grant <= GNT_NONE;
                end
                default: grant <= GNT_NONE;
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign stall_if_o  = if_req_i && !if_ack_o;
    assign stall_mem_o = mem_req_i && !mem_ack_o;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-timeline reference model.
// Honours ARB_FAIRNESS_EN in the same way as the design.
module tb_unified_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    unified_mem_arbiter #(
        .AW(AW), .DW(DW), .LATENCY(LAT), .STREAK_MAX(SMAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: at most one transaction, described by its grant cycle and the port that won it.
    int          txn_port;
    int          g;
    logic        txn_we;
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    int          next_free;
    int          streak;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
    logic [31:0] mem_model [logic [31:0]];

    logic        nxt_rst;
    logic        nxt_if_req;
    logic [31:0] nxt_if_addr;
    logic        nxt_mem_req;
    logic        nxt_mem_we;
    logic [31:0] nxt_mem_addr;
    logic [31:0] nxt_mem_wdata;
    int          hold_reset;
    int          p_if;
    int          p_mem;
    int          p_rst;
    int          p_drop;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 7)) << 2;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic arbitrate();
        int win = 0;
`ifdef ARB_FAIRNESS_EN
        if (!if_req) streak = 0;
        if (if_req && streak == SMAX) win = 1;
        else if (mem_req) win = 2;
        else if (if_req) win = 1;
        if (win == 1) streak = 0;
        else if (win == 2 && if_req) streak++;
`else
        if (mem_req) win = 2;
        else if (if_req) win = 1;
`endif
        if (win != 0) begin
            txn_port  = win;
            g         = cyc;
            txn_we    = (win == 2) && mem_we;
            txn_addr  = (win == 2) ? mem_addr : if_addr;
            txn_wdata = (win == 2) ? mem_wdata : 32'h0;
            next_free = cyc + LAT + 2;
        end else begin
            next_free = cyc + 1;
        end
    endtask

    task automatic apply_stimulus();
        bit active, last, ack_c, exp_ifa, exp_mema, busy_c, wr;
        @(posedge clk);
        #1;
        rst       = nxt_rst;
        if_req    = nxt_if_req;
        if_addr   = nxt_if_addr;
        mem_req   = nxt_mem_req;
        mem_we    = nxt_mem_we;
        mem_addr  = nxt_mem_addr;
        mem_wdata = nxt_mem_wdata;

        active   = (txn_port != 0) && (cyc >= g + 1) && (cyc <= g + LAT);
        last     = (txn_port != 0) && (cyc == g + LAT);
        ack_c    = (txn_port != 0) && (cyc == g + LAT + 1);
        busy_c   = (txn_port != 0) && (cyc >= g + 1) && (cyc <= g + LAT + 1);
        wr       = (txn_port == 2) && txn_we;
        exp_ifa  = ack_c && (txn_port == 1);
        exp_mema = ack_c && (txn_port == 2);
        ram_rdata = (last && !wr) ? mem_read(txn_addr) : $urandom();
        #1;

        check_output("if_ack", 32'(if_ack), 32'(exp_ifa));
        check_output("mem_ack", 32'(mem_ack), 32'(exp_mema));
        check_output("ram_en", 32'(ram_en), 32'(active));
        check_output("ram_we", 32'(ram_we), 32'(last && wr));
        check_output("ram_addr", ram_addr, active ? txn_addr : 32'h0);
        check_output("ram_wdata", ram_wdata, active ? txn_wdata : 32'h0);
        check_output("busy", 32'(busy), 32'(busy_c));
        check_output("stall_if", 32'(stall_if), 32'(if_req && !exp_ifa));
        check_output("stall_mem", 32'(stall_mem), 32'(mem_req && !exp_mema));
        check_output("if_rdata", if_rdata, exp_if_rdata);
        check_output("mem_rdata", mem_rdata, exp_mem_rdata);

        // Memory sees the strobe even if reset lands in the same cycle.
        if (last && wr) mem_model[txn_addr] = txn_wdata;
        if (!rst) begin
            txn_port      = 0;
            streak        = 0;
            exp_if_rdata  = 32'h0;
            exp_mem_rdata = 32'h0;
            next_free     = cyc + 1;
        end else begin
            if (last && !wr) begin
                if (txn_port == 1) exp_if_rdata = ram_rdata;
                else exp_mem_rdata = ram_rdata;
            end
            if (ack_c) txn_port = 0;
            if (cyc == next_free) arbitrate();
        end

        if (hold_reset > 0) begin
            nxt_rst = 1'b0;
            hold_reset--;
        end else begin
            nxt_rst = ($urandom_range(0, 999) < p_rst) ? 1'b0 : 1'b1;
        end

        if (exp_ifa || !if_req) begin
            nxt_if_req = 1'b0;
            if ($urandom_range(0, 99) < p_if) begin
                nxt_if_req  = 1'b1;
                nxt_if_addr = rand_addr();
            end
        end else if (txn_port == 1 && $urandom_range(0, 99) < p_drop) begin
            nxt_if_req  = 1'b0;
            nxt_if_addr = $urandom();
        end

        if (exp_mema || !mem_req) begin
            nxt_mem_req = 1'b0;
            if ($urandom_range(0, 99) < p_mem) begin
                nxt_mem_req   = 1'b1;
                nxt_mem_we    = 1'($urandom_range(0, 1));
                nxt_mem_addr  = rand_addr();
                nxt_mem_wdata = $urandom();
            end
        end else if (txn_port == 2 && $urandom_range(0, 99) < p_drop) begin
            nxt_mem_req   = 1'b0;
            nxt_mem_addr  = $urandom();
            nxt_mem_wdata = $urandom();
            nxt_mem_we    = ~mem_we;
        end
        cyc++;
    endtask

    initial begin
        txn_port      = 0;
        g             = 0;
        txn_we        = 1'b0;
        txn_addr      = 32'h0;
        txn_wdata     = 32'h0;
        next_free     = 0;
        streak        = 0;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
        hold_reset    = 1;

        rst       = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h40;
        mem_wdata = 32'h1234_5678;
        ram_rdata = 32'h0;
        nxt_rst       = 1'b0;
        nxt_if_req    = 1'b1;
        nxt_if_addr   = 32'h10;
        nxt_mem_req   = 1'b1;
        nxt_mem_we    = 1'b0;
        nxt_mem_addr  = 32'h40;
        nxt_mem_wdata = 32'h1234_5678;

        // Mixed traffic with occasional resets and mid-access request drops.
        p_if = 40; p_mem = 40; p_rst = 15; p_drop = 10;
        for (int i = 0; i < 600; i++) apply_stimulus();

        // Saturated data traffic with a fetch waiting: exercises starvation / forced fetch grants.
        p_if = 100; p_mem = 100; p_rst = 0; p_drop = 0;
        for (int i = 0; i < 120; i++) apply_stimulus();

        // Data traffic stops so any starved fetch drains.
        p_if = 50; p_mem = 0;
        for (int i = 0; i < 80; i++) apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
